modo2_unidade_controle: RTL
===========================

Name: modo2_unidade_controle

Overview:
- Control unit for game mode 2, where the player composes the sequence.
- Each round: the stored sequence is shown, the player repeats it, then the player enters one new note, which is written to memory (gravaM).
- Mode 1 only reads and compares the memory; this block is the memory writer.
- Drives the same datapath (address counter C, round counter CR, tone timer TM, register R, memory M).
- Contains an internal player-response timeout counter.

Parameters:
TIMEOUT_CYCLES, 5000, cycles allowed per player input before timeout (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
iniciar  in  1  start/restart request
fimTF  in  1  tone/feedback timer TM expired
fimCR  in  1  round counter at last round
enderecoUltimo  in  1  address counter C == CR-1 (last stored note)
jogada_feita  in  1  player input pulse (1 cycle)
jogada_correta  in  1  R equals M[C]
zeraC, contaC  out  1  address counter clear/increment
zeraTM, contaTM  out  1  tone timer clear/count
zeraCR, contaCR  out  1  round counter clear/increment
zeraR, registraR  out  1  jogada register clear/load
gravaM  out  1  memory write M[C] <= R
ativa_leds_mem, ativa_leds_jog, toca  out  1  LED/buzzer enables
vez_jogador  out  1  waiting for repetition of a stored note
nova_jogada  out  1  waiting for the new note
ganhou, perdeu, pronto  out  1  game result flags
db_timeout  out  1  in estado_timeout
db_estado  out  5  current state code

Behaviour:
Architecture:
- Moore FSM; every output is a pure decode of the current state.
- reset=0 at any time forces inicial immediately and clears the timeout counter.
- Reset output values: all 0 except zeraR=1; db_estado=00.

States (hex code) -> transitions; active outputs:
- inicial 00 -> iniciar ? inicializa : inicial; zeraR.
- inicializa 01 -> espera_nova; zeraCR, zeraC, zeraR, zeraTM. Clears timeout counter.
- espera_nova 02 -> timeout ? estado_timeout : jogada_feita ? registra_nova : stay; nova_jogada.
- registra_nova 03 -> grava; registraR.
- grava 04 -> toca_nova; gravaM for exactly 1 cycle per round, at address C == CR.
- toca_nova 05 -> fimTF ? verifica_fim : stay; toca, ativa_leds_jog, contaTM.
- verifica_fim 06 -> fimCR ? acertou : proxima_rodada; zeraTM.
- proxima_rodada 07 -> mostra; contaCR, zeraC, zeraTM.
- mostra 08 -> espera_mostra; zeraTM.
- espera_mostra 09 -> fimTF ? (enderecoUltimo ? inicio_jogada : apaga_mostra) : stay; toca, ativa_leds_mem, contaTM.
- apaga_mostra 0A -> fimTF ? mostra_proximo : stay; contaTM.
- mostra_proximo 0B -> mostra; contaC.
- inicio_jogada 0C -> espera_jogada; zeraC, zeraTM. Clears timeout counter.
- espera_jogada 0D -> timeout ? estado_timeout : jogada_feita ? registra : stay; vez_jogador.
- registra 0E -> compara; registraR.
- compara 0F, while fimTF=0 -> stay; toca, ativa_leds_jog, contaTM.
- compara 0F, when fimTF=1 -> !jogada_correta ? errou : enderecoUltimo ? avanca_nova : proxima_jogada.
- proxima_jogada 10 -> espera_jogada; contaC, zeraTM. Clears timeout counter.
- avanca_nova 14 -> espera_nova; contaC, zeraTM. Clears timeout counter.
- acertou 11 / errou 12 / estado_timeout 13 -> iniciar ? inicializa : stay.
  - pronto in all three.
  - ganhou in acertou.
  - perdeu in errou and estado_timeout.
  - db_timeout in estado_timeout.
- Any unused code -> inicial.

Timeout counter:
- Width ceil(log2(TIMEOUT_CYCLES)).
- Increments only in espera_nova and espera_jogada.
- Holds in all other states; cleared where noted above.
- timeout = counter == TIMEOUT_CYCLES-1 while in a wait state.
- Counter saturates there and does not wrap.
- Timeout takes priority over a simultaneous jogada_feita.

Round structure:
- Round 0 (CR=0) skips showing and goes straight to espera_nova.
- Round k shows k notes, expects k repetitions, then one new note.
- jogada_feita outside the wait states is ignored.
- iniciar in any non-terminal state other than inicial is ignored.

Test Plan:
- Reset: reset=0 mid-game (state 0D) -> db_estado=00 asynchronously; zeraR=1; all other outputs 0.
- Round 0 write: iniciar, then jogada_feita in 02 -> sequence 03, 04 (gravaM exactly 1 cycle), 05; after fimTF -> 06, then 07 with contaCR=1.
- Round 1 full pass: show one note (09 with ativa_leds_mem, enderecoUltimo=1) -> 0C, 0D; correct play -> 0F, 14 (contaC=1) -> 02 with nova_jogada=1.
- Wrong repetition: jogada_correta=0 at fimTF in 0F -> 12; perdeu=pronto=1; iniciar -> 01.
- Timeout: TIMEOUT_CYCLES=8, no input in 0D -> 13 exactly 8 cycles after entry; db_timeout=1. Same-cycle jogada_feita at the limit -> still 13.
- Win: fimCR=1 in 06 -> 11; ganhou=pronto=1; stays until iniciar.

Source files
------------

// File: rtl/modo2_unidade_controle.sv
// Control unit for game mode 2: plays back the stored sequence, checks the player's
// repetition, then records one new player note into memory each round.
module modo2_unidade_controle #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       iniciar_i,
  input  logic       fimTF_i,
  input  logic       fimCR_i,
  input  logic       enderecoUltimo_i,
  input  logic       jogada_feita_i,
  input  logic       jogada_correta_i,
  output logic       zeraC_o,
  output logic       contaC_o,
  output logic       zeraTM_o,
  output logic       contaTM_o,
  output logic       zeraCR_o,
  output logic       contaCR_o,
  output logic       zeraR_o,
  output logic       registraR_o,
  output logic       gravaM_o,
  output logic       ativa_leds_mem_o,
  output logic       ativa_leds_jog_o,
  output logic       toca_o,
  output logic       vez_jogador_o,
  output logic       nova_jogada_o,
  output logic       ganhou_o,
  output logic       perdeu_o,
  output logic       pronto_o,
  output logic       db_timeout_o,
  output logic [4:0] db_estado_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [4:0] {
    StInicial       = 5'h00,
    StInicializa    = 5'h01,
    StEsperaNova    = 5'h02,
    StRegistraNova  = 5'h03,
    StGrava         = 5'h04,
    StTocaNova      = 5'h05,
    StVerificaFim   = 5'h06,
    StProximaRodada = 5'h07,
    StMostra        = 5'h08,
    StEsperaMostra  = 5'h09,
    StApagaMostra   = 5'h0A,
    StMostraProximo = 5'h0B,
    StInicioJogada  = 5'h0C,
    StEsperaJogada  = 5'h0D,
    StRegistra      = 5'h0E,
    StCompara       = 5'h0F,
    StProximaJogada = 5'h10,
    StAcertou       = 5'h11,
    StErrou         = 5'h12,
    StTimeout       = 5'h13,
    StAvancaNova    = 5'h14
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            em_espera;
  logic            timeout;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StInicial;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign em_espera = (state_q == StEsperaNova) || (state_q == StEsperaJogada);
  assign timeout   = em_espera && (cnt_q == CntMax);

  // Response timer runs only while waiting for the player and saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      StInicializa, StInicioJogada, StProximaJogada, StAvancaNova: cnt_d = '0;
      StEsperaNova, StEsperaJogada: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInicial:       state_d = iniciar_i ? StInicializa : StInicial;
      StInicializa:    state_d = StEsperaNova;
      StEsperaNova: begin
        if (timeout)             state_d = StTimeout;
        else if (jogada_feita_i) state_d = StRegistraNova;
      end
      StRegistraNova:  state_d = StGrava;
      StGrava:         state_d = StTocaNova;
      StTocaNova:      state_d = fimTF_i ? StVerificaFim : StTocaNova;
      StVerificaFim:   state_d = fimCR_i ? StAcertou : StProximaRodada;
      StProximaRodada: state_d = StMostra;
      StMostra:        state_d = StEsperaMostra;
      StEsperaMostra: begin
        if (fimTF_i) state_d = enderecoUltimo_i ? StInicioJogada : StApagaMostra;
      end
      StApagaMostra:   state_d = fimTF_i ? StMostraProximo : StApagaMostra;
      StMostraProximo: state_d = StMostra;
      StInicioJogada:  state_d = StEsperaJogada;
      StEsperaJogada: begin
        if (timeout)             state_d = StTimeout;
        else if (jogada_feita_i) state_d = StRegistra;
      end
      StRegistra:      state_d = StCompara;
      StCompara: begin
        if (fimTF_i) begin
          if (!jogada_correta_i)     state_d = StErrou;
          else if (enderecoUltimo_i) state_d = StAvancaNova;
          else                       state_d = StProximaJogada;
        end
      end
      StProximaJogada: state_d = StEsperaJogada;
      StAvancaNova:    state_d = StEsperaNova;
      StAcertou, StErrou, StTimeout: begin
        if (iniciar_i) state_d = StInicializa;
      end
      default:         state_d = StInicial;
    endcase
  end

  always_comb begin
    zeraC_o          = 1'b0;
    contaC_o         = 1'b0;
    zeraTM_o         = 1'b0;
    contaTM_o        = 1'b0;
    zeraCR_o         = 1'b0;
    contaCR_o        = 1'b0;
    zeraR_o          = 1'b0;
    registraR_o      = 1'b0;
    gravaM_o         = 1'b0;
    ativa_leds_mem_o = 1'b0;
    ativa_leds_jog_o = 1'b0;
    toca_o           = 1'b0;
    vez_jogador_o    = 1'b0;
    nova_jogada_o    = 1'b0;
    ganhou_o         = 1'b0;
    perdeu_o         = 1'b0;
    pronto_o         = 1'b0;
    db_timeout_o     = 1'b0;
    db_estado_o      = state_q;
    case (state_q)
      StInicial:       zeraR_o = 1'b1;
      StInicializa: begin
        zeraCR_o = 1'b1;
        zeraC_o  = 1'b1;
        zeraR_o  = 1'b1;
        zeraTM_o = 1'b1;
      end
      StEsperaNova:    nova_jogada_o = 1'b1;
      StRegistraNova:  registraR_o = 1'b1;
      StGrava:         gravaM_o = 1'b1;
      StTocaNova, StCompara: begin
        toca_o           = 1'b1;
        ativa_leds_jog_o = 1'b1;
        contaTM_o        = 1'b1;
      end
      StVerificaFim, StMostra: zeraTM_o = 1'b1;
      StProximaRodada: begin
        contaCR_o = 1'b1;
        zeraC_o   = 1'b1;
        zeraTM_o  = 1'b1;
      end
      StEsperaMostra: begin
        toca_o           = 1'b1;
        ativa_leds_mem_o = 1'b1;
        contaTM_o        = 1'b1;
      end
      StApagaMostra:   contaTM_o = 1'b1;
      StMostraProximo: contaC_o = 1'b1;
      StInicioJogada: begin
        zeraC_o  = 1'b1;
        zeraTM_o = 1'b1;
      end
      StEsperaJogada:  vez_jogador_o = 1'b1;
      StRegistra:      registraR_o = 1'b1;
      StProximaJogada, StAvancaNova: begin
        contaC_o = 1'b1;
        zeraTM_o = 1'b1;
      end
      StAcertou: begin
        ganhou_o = 1'b1;
        pronto_o = 1'b1;
      end
      StErrou: begin
        perdeu_o = 1'b1;
        pronto_o = 1'b1;
      end
      StTimeout: begin
        perdeu_o     = 1'b1;
        pronto_o     = 1'b1;
        db_timeout_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
